// File: rtl/spi_slave_regbank.sv
// spi_slave_regbank: SPI mode-0 slave decoding 16-bit write/read frames into a bank of 8-bit registers.
// Define SPI_SLAVE_TRISTATE_EN to release miso (1'bz) while chip select is high.
module spi_slave_regbank #(
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_b,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic                  frame_err
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] cs_s, mosi_s;
  logic [2:0] sclk_s;
  logic [4:0] cnt_q;
  logic [6:0] sh_q, addr_q, addr_n;
  logic [7:0] shadow_q, rd_byte;
  logic       rw_q, miso_q, cs_hi, rise, fall, active, last_cmd, last_data, abort;
  assign cs_hi     = cs_s[1];
  assign rise      = sclk_s[1] & ~sclk_s[2];
  assign fall      = ~sclk_s[1] & sclk_s[2];
  assign active    = state_q == CMD || state_q == DATA;
  assign addr_n    = {sh_q[5:0], mosi_s[1]};
  assign last_cmd  = state_q == CMD && rise && cnt_q == 5'd7;
  assign last_data = state_q == DATA && rise && cnt_q == 5'd15;
  assign abort     = cs_hi && active && cnt_q != 5'd0;
  always_comb begin
    state_d = (cs_hi && state_q != IDLE) ? IDLE :
              (state_q == IDLE && !cs_hi) ? CMD :
              last_cmd ? DATA :
              last_data ? DONE : state_q;
  end
  // Out-of-range read addresses fall through to 0x00.
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_REGS; k++)
      if (addr_n == 7'(k)) rd_byte = reg_out[8*k +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s      <= 2'b11;
      sclk_s    <= 3'b000;
      mosi_s    <= 2'b00;
      cnt_q     <= 5'd0;
      sh_q      <= 7'd0;
      addr_q    <= 7'd0;
      rw_q      <= 1'b0;
      shadow_q  <= 8'h00;
      miso_q    <= 1'b0;
      reg_out   <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= 7'd0;
      frame_err <= 1'b0;
    end else begin
      cs_s      <= {cs_s[0], cs_b};
      sclk_s    <= {sclk_s[1:0], sclk};
      mosi_s    <= {mosi_s[0], mosi};
      wr_stb    <= 1'b0;
      frame_err <= abort;
      if (state_q == IDLE) cnt_q <= 5'd0;
      else if (active && rise) begin
        cnt_q <= cnt_q + 5'd1;
        sh_q  <= {sh_q[5:0], mosi_s[1]};
      end
      if (last_cmd) begin
        rw_q     <= sh_q[6];
        addr_q   <= addr_n;
        shadow_q <= rd_byte;
      end
      if (last_data && rw_q && {1'b0, addr_q} < 8'(NUM_REGS)) begin
        wr_stb  <= 1'b1;
        wr_addr <= addr_q;
        for (int k = 0; k < NUM_REGS; k++)
          if (addr_q == 7'(k)) reg_out[8*k +: 8] <= {sh_q, mosi_s[1]};
      end
      // Read data shifts out on sclk falls; miso is forced low everywhere else.
      if (state_q == DATA && !cs_hi) begin
        if (fall && !rw_q) begin
          miso_q   <= shadow_q[7];
          shadow_q <= {shadow_q[6:0], 1'b0};
        end
      end else miso_q <= 1'b0;
    end
  end
`ifdef SPI_SLAVE_TRISTATE_EN
  assign miso = cs_hi ? 1'bz : miso_q;
`else
  assign miso = miso_q;
`endif
endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb_spi_slave_regbank: scoreboard bench driving SPI frames and checking writes, reads and aborts.
module tb_spi_slave_regbank;
  localparam int N = 8;
  logic clk = 0, rst_n = 0, cs_b = 1, sclk = 0, mosi = 0;
  logic miso, wr_stb, frame_err;
  logic [N*8-1:0] reg_out;
  logic [6:0] wr_addr;
  logic [N*8-1:0] model;
  logic [14:0] wr_q[$];
  logic [7:0] rd_q[$];
  logic [15:0] rx;
  int total = 0, bad = 0, stb_cnt = 0, ferr_cnt = 0, s0, f0;

  spi_slave_regbank #(.NUM_REGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .cs_b(cs_b), .sclk(sclk), .mosi(mosi), .miso(miso),
    .reg_out(reg_out), .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (frame_err) ferr_cnt++;
    if (wr_stb) begin
      stb_cnt++;
      if (wr_q.size() == 0) chk("unexpected_wr_stb", 1, 0);
      else begin
        logic [14:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", wr_addr, e[14:8]);
        chk("wr_data", reg_out[wr_addr*8 +: 8], e[7:0]);
      end
    end
  end

  task automatic frame(input logic [15:0] f, input int nbits, output logic [15:0] r);
    r = 0;
    cs_b = 0;
    #60;
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      #60;
      r[15-i] = miso;
      sclk = 1;
      #60;
      sclk = 0;
    end
    #60;
    cs_b = 1;
    #60;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    if (a < N) begin
      wr_q.push_back({a, d});
      model[a*8 +: 8] = d;
    end
    frame({1'b1, a, d}, 16, rx);
    #20;
    chk("wr_miso_low", rx, 0);
    chk("wr_pending", wr_q.size(), 0);
  endtask

  task automatic rd(input logic [6:0] a);
    rd_q.push_back(a < N ? model[a*8 +: 8] : 8'h00);
    frame({1'b0, a, 8'h00}, 16, rx);
    chk("rd_data", rx[7:0], rd_q.pop_front());
  endtask

  initial begin
    model = '0;
    #30;
    chk("rst_regs", reg_out, 0);
    chk("rst_miso", miso, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_addr", wr_addr, 0);
    rst_n = 1;
    #60;
    s0 = stb_cnt;
    wr(7'd3, 8'hA5);
    chk("w3_regs", reg_out, model);
    chk("w3_stb", stb_cnt - s0, 1);
    s0 = stb_cnt;
    rd(7'd3);
    chk("r3_stb", stb_cnt - s0, 0);
    s0 = stb_cnt;
    wr(7'h7F, 8'h12);
    rd(7'h7F);
    chk("oor_regs", reg_out, model);
    chk("oor_stb", stb_cnt - s0, 0);
    s0 = stb_cnt;
    f0 = ferr_cnt;
    frame(16'h8155, 10, rx);
    #40;
    chk("abort_regs", reg_out, model);
    chk("abort_ferr", ferr_cnt - f0, 1);
    chk("abort_stb", stb_cnt - s0, 0);
    wr(7'd1, 8'h55);
    chk("after_abort_regs", reg_out, model);
    s0 = stb_cnt;
    f0 = ferr_cnt;
    wr(7'd0, 8'h11);
    wr(7'd7, 8'h22);
    chk("b2b_regs", reg_out, model);
    chk("b2b_stb", stb_cnt - s0, 2);
    chk("b2b_ferr", ferr_cnt - f0, 0);
    cs_b = 0;
    #60;
    for (int i = 0; i < 12; i++) begin
      mosi = 1'(16'h8299 >> (15 - i));
      #60;
      sclk = 1;
      #60;
      sclk = 0;
    end
    rst_n = 0;
    model = '0;
    #30;
    chk("midrst_regs", reg_out, 0);
    chk("midrst_miso", miso, 0);
    chk("midrst_stb", wr_stb, 0);
    cs_b = 1;
    #40;
    rst_n = 1;
    #60;
    f0 = ferr_cnt;
    s0 = stb_cnt;
    wr(7'd2, 8'h99);
    chk("post_rst_regs", reg_out, model);
    chk("post_rst_stb", stb_cnt - s0, 1);
    chk("post_rst_ferr", ferr_cnt - f0, 0);
    rd(7'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_regbank.md
# spi_slave_regbank

Synthesizable SPI mode-0 slave that terminates frames from `spi_master` and exposes a small bank of 8-bit control registers to the rest of the design. It oversamples `cs_b`, `sclk` and `mosi` in its own system clock domain, decodes a fixed 16-bit write/read frame, and drives `miso` with register contents on reads. It replaces the behavioural slave as the downstream consumer of the master's bus in the Verisocks-driven bench.

## Interface
- `NUM_REGS`, 8: number of 8-bit registers; legal 1..128.
- `clk`  in  1  system clock; must be ≥ 8× the SPI `sclk` frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs_b`  in  1  SPI chip select, active low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, asynchronous to `clk`, idles low.
- `mosi`  in  1  SPI data from master, asynchronous to `clk`.
- `miso`  out  1  SPI data to master.
- `reg_out`  out  NUM_REGS*8  flat register contents; register k at bits [8k+7:8k].
- `wr_stb`  out  1  one-cycle pulse when a register write commits.
- `wr_addr`  out  7  address of the last committed write.
- `frame_err`  out  1  one-cycle pulse on an aborted frame.

## Operation
- Synchronization: `cs_b`, `sclk`, `mosi` each pass through two flops; a third `sclk` flop provides rise and fall detection.
- Frame is MSB first, 16 bits: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data; `mosi` is sampled on detected `sclk` rise.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE → CMD on synchronized `cs_b` fall; bit counter cleared.
  - CMD: shifts 8 bits. On the 8th rise, latch R/W and address. For a read, load the shadow shift register with register[address], or 0x00 if address ≥ NUM_REGS. → DATA.
  - DATA: on a read, each detected `sclk` fall drives the next shadow bit onto `miso`, bit 7 first on the fall after the 8th rise. On the 16th rise of a write with address < NUM_REGS, commit. → DONE.
  - DONE: ignores further `sclk` edges; extra bits are discarded and `miso` holds 0.
  - Any state → IDLE on synchronized `cs_b` rise.
- Commit: register[address] ← data byte, `wr_addr` ← address, `wr_stb` = 1 for one cycle.
- Writes with address ≥ NUM_REGS: no register change, no `wr_stb`.
- Abort: `cs_b` rises in CMD or DATA with bit count ≠ 0. Nothing is written, `frame_err` pulses for one cycle, and the FSM returns to IDLE. `cs_b` toggling with zero bits is not an error.
- `miso` is 0 outside the read data phase (see Configuration).
- Reset (any time, including mid-frame): FSM → IDLE, all registers 0x00, `miso` 0, `wr_stb` 0, `frame_err` 0, `wr_addr` 0, synchronizers cleared to `cs_b`=1, `sclk`=0, `mosi`=0.

## Timing
- Pin edge to internal edge detect: 3 `clk` cycles (2 sync + 1 detect), ±1 for phase.
- `wr_stb` and the `reg_out` update occur in the same cycle, 1 cycle after the 16th rise is detected.
- `miso` changes 1 cycle after the detected `sclk` fall, so about 4 `clk` cycles after the pin edge. This is valid for the master's next rise provided `clk` ≥ 8× `sclk`.
- `frame_err` asserts 1 cycle after the `cs_b` rise is detected.
- Back-to-back frames need ≥ 4 `clk` cycles of `cs_b` high.

## Configuration
- `SPI_SLAVE_TRISTATE_EN`:
  - Defined: `miso` is 1'bz whenever synchronized `cs_b` is high, and driven (data or 0) while selected.
  - Undefined: `miso` is always driven, 0 when not in the read data phase.

## Test plan
- Write frame 0x83A5 (write, addr 3, data 0xA5): `reg_out[31:24]` = 0xA5, one `wr_stb` pulse, `wr_addr` = 3, other registers stay 0x00.
- After the above, read frame 0x0300: master receives 0xA5 on `miso` in bits 7:0, and no `wr_stb`.
- Write frame 0xFF12 (addr 0x7F ≥ NUM_REGS), then read addr 0x7F: no register change, no `wr_stb`, read returns 0x00.
- Write 0x8155, then deassert `cs_b` after 10 bits: register 1 unchanged, `frame_err` pulses once, next complete frame works normally.
- Two back-to-back writes (0x8011, 0x8722) with 4 `clk` of `cs_b` high: registers 0 = 0x11 and 7 = 0x22, two `wr_stb` pulses.
- Assert `rst_n` low at bit 12 of write 0x8299: all `reg_out` = 0, `miso` = 0, FSM in IDLE. After release, write 0x8299: register 2 = 0x99.
